// File: rtl/sram_frame_arbiter.sv
// Arbiter/sequencer for the shared 1M x 16 frame SRAM: VGA read, camera write and host ports.
// Fixed priority rd > wr > host, with a forced host grant once the host has waited too long.
module sram_frame_arbiter #(
    parameter int unsigned ACC_CYC       = 2,
    parameter int unsigned HOST_MAX_WAIT = 64,
    parameter int unsigned AW            = 20
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [15:0]   rd_data,
    output logic          rd_valid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [1:0]    wr_be,
    output logic          wr_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [15:0]   host_wdata,
    input  logic [1:0]    host_be,
    output logic          host_ack,
    output logic [15:0]   host_rdata,
    output logic          host_rvalid,
    output logic          busy,
    output logic [AW-1:0] SRAM_ADDR,
    output logic [15:0]   SRAM_DQ_O,
    output logic          SRAM_DQ_OE,
    input  logic [15:0]   SRAM_DQ_I,
    output logic          SRAM_CE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_WE_N,
    output logic          SRAM_LB_N,
    output logic          SRAM_UB_N
);

    typedef enum logic {IDLE, ACC} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RD, SRC_WR, SRC_HOST} src_t;

    localparam logic [3:0] CNT_LAST  = 4'(ACC_CYC - 1);
    localparam logic [7:0] AGE_LIMIT = 8'(HOST_MAX_WAIT);

    state_t        state;
    logic [3:0]    cnt;
    logic [7:0]    host_age;
    logic          cur_we;
    src_t          cur_src;

    src_t          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [15:0]   win_data;
    logic [1:0]    win_be;
    logic          last_cyc;
    logic          arb_pt;
    logic          grant;

    always_comb begin
        last_cyc = (state == ACC) && (cnt == '0);
        arb_pt   = (state == IDLE) || last_cyc;

        win = SRC_NONE;
        if (host_req && (host_age >= AGE_LIMIT)) win = SRC_HOST;
        else if (rd_req)                         win = SRC_RD;
        else if (wr_req)                         win = SRC_WR;
        else if (host_req)                       win = SRC_HOST;

        win_we   = 1'b0;
        win_addr = '0;
        win_data = '0;
        win_be   = '0;
        case (win)
            SRC_RD: begin
                win_addr = rd_addr;
            end
            SRC_WR: begin
                win_we   = 1'b1;
                win_addr = wr_addr;
                win_data = wr_data;
                win_be   = wr_be;
            end
            SRC_HOST: begin
                win_we   = host_we;
                win_addr = host_addr;
                win_data = host_wdata;
                win_be   = host_be;
            end
            default: ;
        endcase

        // Back-to-back only in the same direction; a direction change parks the bus for one cycle.
        grant = arb_pt && (win != SRC_NONE) && ((state == IDLE) || (win_we == cur_we));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            cnt         <= '0;
            host_age    <= '0;
            cur_we      <= 1'b0;
            cur_src     <= SRC_NONE;
            rd_ack      <= 1'b0;
            wr_ack      <= 1'b0;
            host_ack    <= 1'b0;
            rd_valid    <= 1'b0;
            host_rvalid <= 1'b0;
            rd_data     <= '0;
            host_rdata  <= '0;
            busy        <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_O   <= '0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
        end else begin
            rd_ack      <= 1'b0;
            wr_ack      <= 1'b0;
            host_ack    <= 1'b0;
            rd_valid    <= 1'b0;
            host_rvalid <= 1'b0;

            if (!host_req || (grant && (win == SRC_HOST))) host_age <= '0;
            else if (host_age != 8'hFF)                   host_age <= host_age + 8'd1;

            // Read data is captured at the end of the final access cycle.
            if (last_cyc && !cur_we) begin
                if (cur_src == SRC_RD) begin
                    rd_data  <= SRAM_DQ_I;
                    rd_valid <= 1'b1;
                end else begin
                    host_rdata  <= SRAM_DQ_I;
                    host_rvalid <= 1'b1;
                end
            end

            if (grant) begin
                state     <= ACC;
                cnt       <= CNT_LAST;
                cur_we    <= win_we;
                cur_src   <= win;
                busy      <= 1'b1;
                rd_ack    <= (win == SRC_RD);
                wr_ack    <= (win == SRC_WR);
                host_ack  <= (win == SRC_HOST);
                SRAM_ADDR <= win_addr;
                SRAM_CE_N <= 1'b0;
                if (win_we) begin
                    SRAM_DQ_O  <= win_data;
                    SRAM_DQ_OE <= 1'b1;
                    SRAM_OE_N  <= 1'b1;
                    SRAM_WE_N  <= (win_be == 2'b00);
                    SRAM_LB_N  <= ~win_be[0];
                    SRAM_UB_N  <= ~win_be[1];
                end else begin
                    SRAM_DQ_OE <= 1'b0;
                    SRAM_OE_N  <= 1'b0;
                    SRAM_WE_N  <= 1'b1;
                    SRAM_LB_N  <= 1'b0;
                    SRAM_UB_N  <= 1'b0;
                end
            end else if ((state == ACC) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) SRAM_WE_N <= 1'b1;
            end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                SRAM_DQ_OE <= 1'b0;
                SRAM_CE_N  <= 1'b1;
                SRAM_OE_N  <= 1'b1;
                SRAM_WE_N  <= 1'b1;
                SRAM_LB_N  <= 1'b1;
                SRAM_UB_N  <= 1'b1;
            end
        end
    end

endmodule
